// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : Small in-order FIFO between the Fetch stage (PC + IM) and
//                the Decode stage of the 5-stage MIPS pipeline. Fetch pushes
//                one {instr, pc} pair per cycle. Decode pops the head through
//                a valid/ready handshake. Back-pressure reaches Fetch through
//                in_ready (EnPC). A redirect flush discards every entry.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        pipeline clock, rising edge
//    reset      in   1        asynchronous, active-low reset
//    in_valid   in   1        Fetch offers an instr/PC this cycle
//    in_ready   out  1        buffer can accept (drives EnPC)
//    in_instr   in   32       instruction from IM
//    in_pc      in   32       PC of in_instr
//    flush      in   1        synchronous discard of all entries
//    out_valid  out  1        head entry valid for Decode
//    out_ready  in   1        Decode consumes the head this cycle
//    out_instr  out  32       head instruction, 0 (nop) when empty
//    out_pc     out  32       head PC, 0 when empty
//    out_pc8    out  32       head PC + 8 (link value), 0 when empty
//    count      out  PTR_W+1  occupied entries, 0..DEPTH
// ============================================================================
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc8,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   c_FULL    = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] c_PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   c_CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Each entry holds {instr, pc}.
    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic [63:0]      w_head;

    // in_ready depends only on registered occupancy. A full buffer therefore
    // refuses a push even while Decode pops in the same cycle, which keeps
    // EnPC off any combinational path from the Decode stall logic.
    assign in_ready    = (r_count != c_FULL);
    assign w_not_empty = (r_count != '0);
    assign out_valid   = w_not_empty;

    assign w_push = in_valid & in_ready;
    assign w_pop  = w_not_empty & out_ready;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_instr = w_not_empty ? w_head[63:32] : 32'h0000_0000;
    assign out_pc    = w_not_empty ? w_head[31:0]  : 32'h0000_0000;
    assign out_pc8   = w_not_empty ? (w_head[31:0] + 32'd8) : 32'h0000_0000;
    assign count     = r_count;

    // Entry storage carries no reset: contents are only observed once
    // r_count says they were written. A push that coincides with a flush is
    // dropped, so it is not written either.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {in_instr, in_pc};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Directed self-checking bench for if_id_buffer (DEPTH = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic [1:0]  count;

    int n_vec = 0;
    int n_err = 0;

    if_id_buffer #(.DEPTH(2), .PTR_W(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_pc8   (out_pc8),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int recv;
        logic hs_push;
        logic hs_pop;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr,      32'h0);
        chk("rst_out_pc8",   out_pc8,        32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Single push, then pop
        in_valid = 1'b1; in_instr = 32'h3C01_1234; in_pc = 32'h0000_3000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_instr", out_instr,      32'h3C01_1234);
        chk("single_pc",    out_pc,         32'h0000_3000);
        chk("single_pc8",   out_pc8,        32'h0000_3008);
        chk("single_count", 32'(count),     32'd1);
        step();
        chk("single_empty_valid", 32'(out_valid), 32'd0);
        chk("single_empty_count", 32'(count),     32'd0);
        chk("single_empty_pc",    out_pc,         32'h0);
        chk("single_empty_pc8",   out_pc8,        32'h0);

        // Fill and back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h1111_0000; in_pc = 32'h0000_3000;
        step();
        chk("fill1_head", out_pc, 32'h0000_3000);
        in_instr = 32'h1111_0004; in_pc = 32'h0000_3004;
        step();
        chk("fill2_count",    32'(count),    32'd2);
        chk("fill2_in_ready", 32'(in_ready), 32'd0);
        chk("fill2_head",     out_pc,        32'h0000_3000);
        in_instr = 32'h1111_0008; in_pc = 32'h0000_3008;
        step();
        chk("refused_count", 32'(count), 32'd2);
        chk("refused_head",  out_pc,     32'h0000_3000);
        chk("refused_instr", out_instr,  32'h1111_0000);

        // Full with pop and offered push: pop only
        out_ready = 1'b1;
        step();
        chk("fullpop_count",    32'(count),    32'd1);
        chk("fullpop_head",     out_pc,        32'h0000_3004);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step();
        chk("late_push_count", 32'(count), 32'd2);
        chk("late_push_head",  out_pc,     32'h0000_3004);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("pop_head",  out_pc,     32'h0000_3008);
        chk("pop_instr", out_instr,  32'h1111_0008);
        chk("pop_count", 32'(count), 32'd1);

        // Simultaneous push/pop at count=1
        in_valid = 1'b1; in_instr = 32'h1111_000C; in_pc = 32'h0000_300C; out_ready = 1'b1;
        step();
        chk("pushpop_count", 32'(count), 32'd1);
        chk("pushpop_head",  out_pc,     32'h0000_300C);
        chk("pushpop_pc8",   out_pc8,    32'h0000_3014);

        // Flush with concurrent push
        in_instr = 32'h1111_0010; in_pc = 32'h0000_3010; out_ready = 1'b0;
        step();
        chk("preflush_count", 32'(count), 32'd2);
        flush = 1'b1; in_instr = 32'h2222_4000; in_pc = 32'h0000_4000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_instr", out_instr,      32'h0);
        step();
        chk("flush_lost_count", 32'(count), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("after_flush_head",  out_pc,     32'h0000_4000);
        chk("after_flush_instr", out_instr,  32'h2222_4000);
        chk("after_flush_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        chk("after_flush_drain", 32'(count), 32'd0);

        // Wrap: six sequential PCs with alternating out_ready
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            in_valid  = (sent < 6);
            in_pc     = 32'h0000_3000 + 32'(sent * 4);
            in_instr  = 32'hA000_0000 | in_pc;
            out_ready = cyc[0];
            #1;
            hs_push = in_valid & in_ready;
            hs_pop  = out_valid & out_ready;
            if (hs_pop) begin
                chk("wrap_pc",    out_pc,    32'h0000_3000 + 32'(recv * 4));
                chk("wrap_instr", out_instr, 32'hA000_3000 + 32'(recv * 4));
                recv++;
            end
            if (hs_push) sent++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("wrap_recv",  32'(recv),  32'd6);
        chk("wrap_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with count=2
        in_valid = 1'b1; in_instr = 32'h5555_0000; in_pc = 32'h0000_5000;
        step();
        in_pc = 32'h0000_5004;
        step();
        in_valid = 1'b0;
        chk("prereset_count", 32'(count), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_count",    32'(count),     32'd0);
        chk("async_rst_valid",    32'(out_valid), 32'd0);
        chk("async_rst_instr",    out_instr,      32'h0);
        chk("async_rst_pc",       out_pc,         32'h0);
        chk("async_rst_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
